// File: rtl/powergate_ack_pkg.sv
// Shared types and constants for the power-switch acknowledge model.
package powergate_ack_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } chan_state_e;

  localparam int DEFAULT_LAT = 15;

endpackage

// File: rtl/powergate_ack_channel.sv
// One emulated switch cell: delays a request change by a sampled latency
// before reflecting it on ack, with cancel and freeze (stuck fault) support.
module powergate_ack_channel
  import powergate_ack_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter bit RST_ACK = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             switch_i,
  input  logic [CNT_W-1:0] lat_on_i,
  input  logic [CNT_W-1:0] lat_off_i,
  input  logic             fault_stuck_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic             ack_evt_o
);

  chan_state_e      state_q, state_nxt;
  logic             tgt_q, tgt_nxt;
  logic             ack_q, ack_nxt;
  logic             evt_q, evt_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] lat_sel;

  // A zero latency still costs one edge, so the counter never starts at 0.
  always_comb begin
    lat_sel = switch_i ? lat_off_i : lat_on_i;
    if (lat_sel == '0) lat_sel = CNT_W'(1);
  end

  always_comb begin
    state_nxt = state_q;
    tgt_nxt   = tgt_q;
    cnt_nxt   = cnt_q;
    ack_nxt   = ack_q;
    evt_nxt   = 1'b0;
    if (!fault_stuck_i) begin
      unique case (state_q)
        ST_STABLE: begin
          if (switch_i != ack_q) begin
            tgt_nxt   = switch_i;
            cnt_nxt   = lat_sel;
            state_nxt = ST_COUNTING;
          end
        end
        ST_COUNTING: begin
          // Request returning to the current ack wins over completion.
          if (switch_i == ack_q) begin
            cnt_nxt   = '0;
            state_nxt = ST_STABLE;
          end else if (cnt_q == CNT_W'(1)) begin
            ack_nxt   = tgt_q;
            cnt_nxt   = '0;
            evt_nxt   = 1'b1;
            state_nxt = ST_STABLE;
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        default: state_nxt = ST_STABLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE;
      tgt_q   <= RST_ACK;
      ack_q   <= RST_ACK;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tgt_q   <= tgt_nxt;
      ack_q   <= ack_nxt;
      evt_q   <= evt_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign ack_o     = ack_q;
  assign busy_o    = (state_q == ST_COUNTING);
  assign ack_evt_o = evt_q;

endmodule

// File: rtl/powergate_ack_model.sv
// Array of independent power-switch acknowledge emulators sharing the
// on/off latency settings.
module powergate_ack_model
  import powergate_ack_pkg::*;
#(
  parameter int                NUM_CH  = 4,
  parameter int                CNT_W   = 8,
  parameter logic [NUM_CH-1:0] RST_ACK = '1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] switch_i,
  input  logic [CNT_W-1:0]  lat_on_i,
  input  logic [CNT_W-1:0]  lat_off_i,
  input  logic [NUM_CH-1:0] fault_stuck_i,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] ack_evt_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    powergate_ack_channel #(
      .CNT_W   (CNT_W),
      .RST_ACK (RST_ACK[c])
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .switch_i      (switch_i[c]),
      .lat_on_i      (lat_on_i),
      .lat_off_i     (lat_off_i),
      .fault_stuck_i (fault_stuck_i[c]),
      .ack_o         (ack_o[c]),
      .busy_o        (busy_o[c]),
      .ack_evt_o     (ack_evt_o[c])
    );
  end

endmodule

// File: tb/tb_powergate_ack_model.sv
// Randomized bench for powergate_ack_model against a deadline-based model.
module tb_powergate_ack_model;
  import powergate_ack_pkg::*;

  localparam int                NUM_CH  = 4;
  localparam int                CNT_W   = 8;
  localparam logic [NUM_CH-1:0] RST_ACK = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sw, fault, ack, busy, evt;
  logic [CNT_W-1:0]  lat_on, lat_off;

  always #5 clk = ~clk;

  powergate_ack_model #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .RST_ACK (RST_ACK)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .switch_i      (sw),
    .lat_on_i      (lat_on),
    .lat_off_i     (lat_off),
    .fault_stuck_i (fault),
    .ack_o         (ack),
    .busy_o        (busy),
    .ack_evt_o     (evt)
  );

  int checks   = 0;
  int failures = 0;

  // Model: a transition is an absolute completion edge number that slips
  // by one for every frozen edge.
  logic [NUM_CH-1:0] m_ack, m_busy, m_evt, m_tgt;
  int                due [NUM_CH];
  int                cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_ack[c]  = RST_ACK[c];
        m_busy[c] = 1'b0;
        m_evt[c]  = 1'b0;
      end else if (fault[c]) begin
        m_evt[c] = 1'b0;
        due[c]   = due[c] + 1;
      end else if (!m_busy[c]) begin
        m_evt[c] = 1'b0;
        if (sw[c] != m_ack[c]) begin
          int lat;
          lat       = sw[c] ? int'(lat_off) : int'(lat_on);
          if (lat == 0) lat = 1;
          m_busy[c] = 1'b1;
          m_tgt[c]  = sw[c];
          due[c]    = cyc + lat;
        end
      end else if (sw[c] == m_ack[c]) begin
        m_busy[c] = 1'b0;
        m_evt[c]  = 1'b0;
      end else if (cyc == due[c]) begin
        m_ack[c]  = m_tgt[c];
        m_busy[c] = 1'b0;
        m_evt[c]  = 1'b1;
      end else begin
        m_evt[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("ack",  int'(ack),  int'(m_ack));
    chk("busy", int'(busy), int'(m_busy));
    chk("evt",  int'(evt),  int'(m_evt));
  endtask

  initial begin
    m_ack  = '0;
    m_busy = '0;
    m_evt  = '0;
    m_tgt  = '0;
    for (int c = 0; c < NUM_CH; c++) due[c] = 0;
    rst     = 1'b1;
    sw      = RST_ACK;
    fault   = '0;
    lat_on  = CNT_W'(DEFAULT_LAT);
    lat_off = CNT_W'(3);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Directed: ch0 power-on with the default latency, ch1 on then off.
    sw[0] = 1'b0;
    sw[1] = 1'b0;
    repeat (20) step();
    sw[1] = 1'b1;
    repeat (6) step();

    // Directed: cancel mid-count, then a stuck fault in the middle of a count.
    lat_on = CNT_W'(10);
    sw[2]  = 1'b0;
    repeat (4) step();
    sw[2]  = 1'b1;
    repeat (4) step();
    lat_on = CNT_W'(8);
    sw[2]  = 1'b0;
    repeat (4) step();
    fault[2] = 1'b1;
    repeat (5) step();
    fault[2] = 1'b0;
    repeat (10) step();

    // Directed: reset in the middle of a count, request held across it.
    lat_on  = CNT_W'(15);
    lat_off = CNT_W'(15);
    sw      = ~m_ack;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (18) step();

    // Random traffic: toggles, latency churn (incl. 0), faults, resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(19) == 0) sw[c] = ~sw[c];
        if (fault[c]) fault[c] = ($urandom_range(3) != 0);
        else          fault[c] = ($urandom_range(29) == 0);
      end
      lat_on  = CNT_W'($urandom_range(24));
      lat_off = CNT_W'($urandom_range(24));
      step();
    end

    // Maximum latency on every channel, no wrap.
    rst     = 1'b0;
    fault   = '0;
    lat_on  = '1;
    lat_off = '1;
    repeat (3) step();
    sw = ~m_ack;
    repeat (260) step();
    sw = ~sw;
    repeat (260) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/powergate_ack_model.md
POWERGATE_ACK_MODEL -- requirements
Module: powergate_ack_model

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent power-switch channels.
REQ-002 SHALL have parameter CNT_W, default 8, width of the latency counters and latency inputs.
REQ-003 SHALL have parameter RST_ACK, default all-ones NUM_CH bits, ack value per channel after reset (switch-off state, active-low).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port switch_i  input  NUM_CH  requested switch state per channel.
REQ-007 SHALL have port lat_on_i  input  CNT_W  latency in cycles for a 1->0 request (power-on), sampled at request change.
REQ-008 SHALL have port lat_off_i  input  CNT_W  latency in cycles for a 0->1 request (power-off), sampled at request change.
REQ-009 SHALL have port fault_stuck_i  input  NUM_CH  per-channel fault injection; freezes that channel.
REQ-010 SHALL have port ack_o  output  NUM_CH  emulated switch-cell acknowledge, registered.
REQ-011 SHALL have port busy_o  output  NUM_CH  channel has a transition in flight.
REQ-012 SHALL have port ack_evt_o  output  NUM_CH  one-cycle pulse on the cycle ack_o changes.

Function
REQ-013 Each channel SHALL hold registers target, ack, counter and a two-state FSM STABLE/COUNTING; channels SHALL be fully independent.
REQ-014 In STABLE, when switch_i[c] != ack[c] at an edge: target <= switch_i[c]; counter <= selected latency (lat_on_i if switch_i[c]=0, else lat_off_i); state -> COUNTING.
REQ-015 Selected latency of 0 SHALL be treated as 1; minimum observable latency is 1 cycle.
REQ-016 Timing: request sampled at edge k with latency L SHALL produce ack_o change at edge k+L, with ack_evt_o high for exactly the following cycle.
REQ-017 In COUNTING, counter SHALL decrement by 1 per cycle; at the edge where counter==1, ack <= target, state -> STABLE, ack_evt pulses.
REQ-018 In COUNTING, if switch_i[c] returns to ack[c]: transition cancelled, state -> STABLE, ack unchanged, no ack_evt.
REQ-019 In COUNTING, if switch_i[c] != target (only possible after cancel+reissue within one edge is impossible, so cancel takes precedence): a new request SHALL be evaluated only from STABLE on the next edge.
REQ-020 lat_on_i/lat_off_i changes during COUNTING SHALL NOT affect the in-flight count.
REQ-021 While fault_stuck_i[c]=1: counter frozen, ack held, no state change, request changes ignored; on deassertion the channel resumes from its frozen state and re-evaluates switch_i[c].
REQ-022 busy_o[c] SHALL equal (state==COUNTING), including while frozen.
REQ-023 Counter SHALL never wrap; maximum latency 2^CNT_W-1 cycles.

Reset
REQ-024 At a clock edge with rst_i=1: ack_o=RST_ACK, target=RST_ACK, counter=0, state=STABLE, busy_o=0, ack_evt_o=0, regardless of activity.
REQ-025 Reset mid-COUNTING SHALL abort the transition with no ack_evt; after release a differing switch_i starts a fresh count.

Structure
REQ-026 A shared package powergate_ack_pkg SHALL hold the channel FSM state enum and default latency constants (DEFAULT_LAT=15).
REQ-027 Per-channel logic SHALL be one sub-module powergate_ack_channel, instantiated NUM_CH times by generate.
REQ-028 The harness SHALL connect switch_i to the subsystem powergate switch signals and ack_o to the matching ack inputs, replacing fixed shift-register delay lines.

Verification
REQ-029 lat_on_i=15, ch0 switch 1->0 at edge 10 -> ack_o[0]=0 at edge 25, ack_evt_o[0] high one cycle, busy_o[0] high edges 10..24.
REQ-030 lat_off_i=3, lat_on_i=20, ch1 off->on then on->off -> on ack after 20 cycles, off ack after 3 cycles.
REQ-031 lat_on_i=10, switch 1->0 at edge 0, back to 1 at edge 4 -> ack_o stays 1, no ack_evt, busy_o low from edge 5.
REQ-032 lat_on_i=0 -> ack changes exactly 1 cycle after sampling; lat_on_i=255 with CNT_W=8 -> 255 cycles, no wrap.
REQ-033 lat_on_i=8, fault_stuck_i[2] high for 5 cycles at count 4 -> ack delayed to 13 cycles total; other channels unaffected.
REQ-034 rst_i pulsed at count 6 of 15 on all channels -> ack_o=RST_ACK, busy_o=0, no ack_evt; held request restarts full 15-cycle count.
